// File: rtl/vga_sync_controller.sv
// VGA timing generator: pixel-rate divider, horizontal/vertical counters with
// segment-tracking sub-FSMs, and a run/stop control FSM that only returns to
// idle at a frame boundary. Every output is a register loaded from the same
// next-state values as the counters, so the outputs line up with the counts.
module vga_sync_controller #(
  parameter int unsigned PIX_DIV  = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Enable,
  output logic       pixel_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_start,
  output logic       running
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  // Last count of each segment; segment lengths are assumed non-zero.
  localparam logic [9:0] H_A_END = 10'(H_ACTIVE - 1);
  localparam logic [9:0] H_F_END = 10'(H_ACTIVE + H_FP - 1);
  localparam logic [9:0] H_S_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_A_END = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_F_END = 10'(V_ACTIVE + V_FP - 1);
  localparam logic [9:0] V_S_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
  typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYNC_S, H_BACK} hseg_t;
  typedef enum logic [1:0] {V_ACT, V_FRONT, V_SYNC_S, V_BACK} vseg_t;

  state_t           state_q, state_d;
  hseg_t            h_seg_q, h_seg_d;
  vseg_t            v_seg_q, v_seg_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_cnt_q, h_cnt_d;
  logic [9:0]       v_cnt_q, v_cnt_d;

  logic       pixel_tick_q, pixel_tick_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic [9:0] pixel_x_q, pixel_x_d;
  logic [9:0] pixel_y_q, pixel_y_d;
  logic       frame_start_q, frame_start_d;
  logic       running_q, running_d;

  logic tick, h_last, v_last, active_d;

  // Control FSM: idle returns only at the final pixel slot of a frame.
  always_comb begin
    tick    = (state_q != IDLE) && (div_q == DIV_LAST);
    h_last  = (h_cnt_q == H_LAST);
    v_last  = (v_cnt_q == V_LAST);
    state_d = state_q;
    case (state_q)
      IDLE:     if (Enable) state_d = RUN;
      RUN:      if (!Enable) state_d = STOPPING;
      STOPPING: begin
        if (Enable)                          state_d = RUN;
        else if (tick && h_last && v_last)   state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  // Divider, counters and segment sub-FSMs advance on pixel slots.
  always_comb begin
    div_d   = div_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    h_seg_d = h_seg_q;
    v_seg_d = v_seg_q;
    if (state_d == IDLE) begin
      div_d   = '0;
      h_cnt_d = '0;
      v_cnt_d = '0;
      h_seg_d = H_ACT;
      v_seg_d = V_ACT;
    end else if (state_q != IDLE) begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
      if (tick) begin
        h_cnt_d = h_last ? '0 : h_cnt_q + 10'd1;
        case (h_seg_q)
          H_ACT:    if (h_cnt_q == H_A_END) h_seg_d = H_FRONT;
          H_FRONT:  if (h_cnt_q == H_F_END) h_seg_d = H_SYNC_S;
          H_SYNC_S: if (h_cnt_q == H_S_END) h_seg_d = H_BACK;
          H_BACK:   if (h_last)             h_seg_d = H_ACT;
          default:  h_seg_d = H_ACT;
        endcase
        if (h_last) begin
          v_cnt_d = v_last ? '0 : v_cnt_q + 10'd1;
          case (v_seg_q)
            V_ACT:    if (v_cnt_q == V_A_END) v_seg_d = V_FRONT;
            V_FRONT:  if (v_cnt_q == V_F_END) v_seg_d = V_SYNC_S;
            V_SYNC_S: if (v_cnt_q == V_S_END) v_seg_d = V_BACK;
            V_BACK:   if (v_last)             v_seg_d = V_ACT;
            default:  v_seg_d = V_ACT;
          endcase
        end
      end
    end
  end

  // Output next-values derived from next counter state for zero latency.
  always_comb begin
    active_d      = (state_d != IDLE);
    pixel_tick_d  = active_d && (div_d == DIV_LAST);
    hsync_d       = !(active_d && (h_seg_d == H_SYNC_S));
    vsync_d       = !(active_d && (v_seg_d == V_SYNC_S));
    video_on_d    = active_d && (h_seg_d == H_ACT) && (v_seg_d == V_ACT);
    pixel_x_d     = active_d ? h_cnt_d : '0;
    pixel_y_d     = active_d ? v_cnt_d : '0;
    frame_start_d = pixel_tick_d && (h_cnt_d == '0) && (v_cnt_d == '0);
    running_d     = active_d;
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      h_seg_q       <= H_ACT;
      v_seg_q       <= V_ACT;
      div_q         <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      pixel_tick_q  <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      frame_start_q <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_seg_q       <= h_seg_d;
      v_seg_q       <= v_seg_d;
      div_q         <= div_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      pixel_tick_q  <= pixel_tick_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      frame_start_q <= frame_start_d;
      running_q     <= running_d;
    end
  end

  assign pixel_tick  = pixel_tick_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign frame_start = frame_start_q;
  assign running     = running_q;

endmodule

// File: doc/vga_sync_controller.md
VGA_SYNC_CONTROLLER -- requirements
Module: vga_sync_controller

Interface
REQ-001 Parameter PIX_DIV, default 2: Clk cycles per pixel.
REQ-002 Parameters H_ACTIVE, H_FP, H_SYNC, H_BP, defaults 640, 16, 96, 48: horizontal segment lengths in pixels.
REQ-003 Parameters V_ACTIVE, V_FP, V_SYNC, V_BP, defaults 480, 10, 2, 33: vertical segment lengths in lines.
REQ-004 Clk  input  1  system clock (50 MHz nominal); all logic on posedge Clk.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 Enable  input  1  level request to run the timing generator.
REQ-007 pixel_tick  output  1  one-Clk pulse marking each pixel slot.
REQ-008 hsync  output  1  horizontal sync, active-low.
REQ-009 vsync  output  1  vertical sync, active-low.
REQ-010 video_on  output  1  high while (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE) in RUN or STOPPING.
REQ-011 pixel_x  output  10  current horizontal count h_cnt, 0..H_TOTAL-1.
REQ-012 pixel_y  output  10  current vertical count v_cnt, 0..V_TOTAL-1.
REQ-013 frame_start  output  1  one-Clk pulse at the first pixel of each frame.
REQ-014 running  output  1  high in RUN or STOPPING.

Function
REQ-015 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 default); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 default); frame = H_TOTAL*V_TOTAL*PIX_DIV Clk cycles (840000 default).
REQ-016 Control FSM states IDLE, RUN, STOPPING; encoding at implementer's choice.
REQ-017 IDLE -> RUN on the Clk edge where Enable=1; h_cnt, v_cnt and the divider are 0 on entry to RUN.
REQ-018 RUN -> STOPPING on the Clk edge where Enable=0.
REQ-019 STOPPING -> RUN when Enable=1 again before frame end; timing continues uninterrupted, with no counter reset.
REQ-020 STOPPING -> IDLE on the pixel_tick where h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1; counters load 0.
REQ-021 Divider counts 0..PIX_DIV-1 in RUN/STOPPING; pixel_tick=1 exactly when divider = PIX_DIV-1; divider and pixel_tick are held at 0 in IDLE.
REQ-022 h_cnt increments on pixel_tick and wraps H_TOTAL-1 -> 0; v_cnt increments only on the pixel_tick where h_cnt wraps, and wraps V_TOTAL-1 -> 0.
REQ-023 Horizontal sub-FSM H_ACT, H_FRONT, H_SYNC_S, H_BACK tracks the h_cnt segments; the vertical sub-FSM V_ACT, V_FRONT, V_SYNC_S, V_BACK tracks v_cnt and advances only at line wrap.
REQ-024 hsync=0 iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751 default), in RUN/STOPPING.
REQ-025 vsync=0 iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491 default), in RUN/STOPPING.
REQ-026 All outputs are registered; hsync, vsync, video_on, pixel_x and pixel_y are valid in the same cycle as the count they describe, with zero latency relative to the counter registers.
REQ-027 frame_start=1 for exactly the one Clk where pixel_tick=1, h_cnt=0, v_cnt=0 and state is RUN or STOPPING.
REQ-028 In IDLE: hsync=1, vsync=1, video_on=0, pixel_x=0, pixel_y=0, frame_start=0, running=0.
REQ-029 All counter arithmetic is unsigned; widths are sized for the defaults, with no overflow beyond TOTAL-1.

Reset
REQ-030 Reset has priority over Enable and over every FSM transition.
REQ-031 While Reset=1, on each Clk: state=IDLE, divider=0, h_cnt=0, v_cnt=0, pixel_tick=0, hsync=1, vsync=1, video_on=0, pixel_x=0, pixel_y=0, frame_start=0, running=0.
REQ-032 Reset asserted mid-frame takes effect on that edge; no partial line or frame completes.
REQ-033 After Reset deasserts with Enable=1, RUN is entered on the next Clk edge.

Verification
REQ-034 Reset 3 cycles, then Enable=1 -> running=1 next edge; first frame_start within PIX_DIV cycles; next frame_start exactly 840000 Clk later.
REQ-035 Run one full line -> hsync low for 192 consecutive Clk (96 px * 2); hsync falls when pixel_x=656; video_on high for 1280 Clk per active line.
REQ-036 Run one full frame -> vsync low for 2 lines (3200 Clk) starting when pixel_y=490; video_on=0 for every pixel_y >= 480.
REQ-037 Drop Enable at pixel (100,200) -> state STOPPING, timing continues to (799,524), then IDLE with hsync=vsync=1; raising Enable again at (300,300) instead keeps RUN with no counter discontinuity.
REQ-038 Assert Reset for 1 cycle at (700,491) -> all outputs take reset values next edge; with Enable held high, restart from (0,0) and frame_start after PIX_DIV cycles.
REQ-039 Enable=1 and Reset=1 together -> IDLE is held and no pixel_tick is issued until Reset=0.
